// File: rtl/display_mux.sv
// Two-digit time-multiplexer for a shared hex-to-7-seg decoder with a blanking gap before each digit.
// Optional leading-zero blanking of digit 1 is enabled by defining DISPLAY_MUX_LZB_EN.
module display_mux #(
    parameter int SHOW_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [3:0] s,
    output logic [1:0] an,
    output logic       frame
);
    typedef enum logic [1:0] {BLANK0, SHOW0, BLANK1, SHOW1} state_t;

`ifdef DISPLAY_MUX_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       s_q, s_d;
    logic [1:0]       an_q, an_d;
    logic             frame_q, frame_d;
    logic             last;

    always_comb begin
        if (state_q == BLANK0 || state_q == BLANK1)
            last = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
        else
            last = (cnt_q == CNT_W'(SHOW_CYCLES - 1));
    end

    // Outputs are computed one edge ahead so an/s/frame change with the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
        s_d     = s_q;
        an_d    = an_q;
        frame_d = 1'b0;
        case (state_q)
            BLANK0: begin
                s_d = s0;
                if (last) begin
                    state_d = SHOW0;
                    an_d    = 2'b10;
                end
            end
            SHOW0: begin
                if (last) begin
                    state_d = BLANK1;
                    an_d    = 2'b11;
                end
            end
            BLANK1: begin
                s_d = s1;
                if (last) begin
                    state_d = SHOW1;
                    an_d    = (LZB && s1 == 4'h0) ? 2'b11 : 2'b01;
                end
            end
            SHOW1: begin
                if (last) begin
                    state_d = BLANK0;
                    an_d    = 2'b11;
                    frame_d = 1'b1;
                end
            end
            default: state_d = BLANK0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BLANK0;
            cnt_q   <= '0;
            s_q     <= 4'h0;
            an_q    <= 2'b11;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign s     = s_q;
    assign an    = an_q;
    assign frame = frame_q;
endmodule
